// File: rtl/prbs_checker.sv
// ============================================================================
// Module   : prbs_checker
// Purpose  : Self-synchronising serial LFSR checker with lock FSM and
//            saturating error / bit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_CNT   = 16,
  parameter int LOSS_CNT   = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] tap,
  input  logic                  rx_valid,
  input  logic                  rx_bit,
  input  logic                  clr,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      bit_cnt
);

  localparam int c_FW = $clog2(DATA_WIDTH + 1);
  localparam int c_MW = $clog2(LOCK_CNT + 1);
  localparam int c_BW = $clog2(LOSS_CNT + 1);
  localparam logic [c_FW-1:0]  c_FILL_FULL = c_FW'(DATA_WIDTH);
  localparam logic [c_MW-1:0]  c_LOCK_LAST = c_MW'(LOCK_CNT - 1);
  localparam logic [c_BW-1:0]  c_LOSS_LAST = c_BW'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tap;
  logic [DATA_WIDTH-1:0] r_h, w_h_nxt;
  logic [c_FW-1:0]       r_fill, w_fill_nxt;
  logic [c_MW-1:0]       r_match, w_match_nxt;
  logic [c_BW-1:0]       r_bad, w_bad_nxt;
  logic                  r_err_pulse;
  logic [CNT_W-1:0]      r_err_cnt, r_bit_cnt;
  logic                  w_exp;
  logic                  w_err_hit;
  logic                  w_count;

  assign w_exp = ^(r_h & r_tap);

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_bad_nxt   = r_bad;
    w_err_hit   = 1'b0;
    w_count     = 1'b0;
    if (rx_valid) begin
      case (r_state)
        SEARCH: begin
          w_h_nxt = {rx_bit, r_h[DATA_WIDTH-1:1]};
          if (r_fill < c_FILL_FULL) begin
            w_fill_nxt = r_fill + c_FW'(1);
          end else if ((rx_bit == w_exp) && (r_h != '0)) begin
            w_match_nxt = r_match + c_MW'(1);
            if (r_match == c_LOCK_LAST) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a single line error costs one count
          w_h_nxt = {w_exp, r_h[DATA_WIDTH-1:1]};
          w_count = 1'b1;
          if (rx_bit != w_exp) begin
            w_err_hit = 1'b1;
            w_bad_nxt = r_bad + c_BW'(1);
            if (r_bad == c_LOSS_LAST) begin
              w_state_nxt = SEARCH;
              w_fill_nxt  = '0;
              w_match_nxt = '0;
            end
          end else begin
            w_bad_nxt = '0;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= SEARCH;
      r_tap       <= tap;
      r_h         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_bad       <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_h         <= w_h_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_bad       <= w_bad_nxt;
      r_err_pulse <= w_err_hit;
      if (clr) begin
        r_err_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_count && (r_bit_cnt != c_CNT_MAX)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (w_err_hit && (r_err_cnt != c_CNT_MAX)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign bit_cnt   = r_bit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// Module   : tb_prbs_checker
// Purpose  : Directed self-checking bench for prbs_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  tap = 8'h1D;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] bit_cnt;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] r_gen;
  logic [7:0] r_gen_tap;

  prbs_checker #(
    .DATA_WIDTH(8),
    .LOCK_CNT  (16),
    .LOSS_CNT  (4),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tap      (tap),
    .rx_valid (rx_valid),
    .rx_bit   (rx_bit),
    .clr      (clr),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_raw(input logic v, input logic b, input logic c);
    rx_valid = v;
    rx_bit   = b;
    clr      = c;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    clr      = 1'b0;
  endtask

  // One beat of the reference generator: emit state bit 0, then right shift
  task automatic step(input logic v, input logic flip, input logic c);
    step_raw(v, v ? (r_gen[0] ^ flip) : 1'b0, c);
    if (v) r_gen = {^(r_gen & r_gen_tap), r_gen[7:1]};
  endtask

  task automatic do_reset(input logic [7:0] t, input logic [7:0] seed);
    resetn    = 1'b0;
    tap       = t;
    r_gen_tap = t;
    r_gen     = seed;
    rx_valid  = 1'b0;
    clr       = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tap    = 8'h00;
  endtask

  initial begin
    do_reset(8'h1D, 8'h01);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_bit", bit_cnt, 0);

    repeat (23) step(1, 0, 0);
    chk("lock_b23", locked, 0);
    step(1, 0, 0);
    chk("lock_b24", locked, 1);
    chk("lock_err", err_cnt, 0);
    chk("lock_bit", bit_cnt, 0);

    repeat (100) step(1, 0, 0);
    chk("run100_bit", bit_cnt, 100);
    chk("run100_err", err_cnt, 0);

    step(1, 1, 0);
    chk("flip1_err", err_cnt, 1);
    chk("flip1_pulse", err_pulse, 1);
    chk("flip1_locked", locked, 1);
    step(1, 0, 0);
    chk("flip1_pulse_off", err_pulse, 0);
    repeat (49) step(1, 0, 0);
    chk("clean50_err", err_cnt, 1);
    chk("clean50_bit", bit_cnt, 151);
    chk("clean50_locked", locked, 1);

    step(1, 0, 1);
    chk("clr_err", err_cnt, 0);
    chk("clr_bit", bit_cnt, 0);
    repeat (3) step(1, 1, 0);
    chk("flip3_locked", locked, 1);
    chk("flip3_err", err_cnt, 3);
    step(1, 1, 0);
    chk("flip4_locked", locked, 0);
    chk("flip4_err", err_cnt, 4);
    chk("flip4_bit", bit_cnt, 4);
    chk("flip4_pulse", err_pulse, 1);
    repeat (23) step(1, 0, 0);
    chk("relock_b23", locked, 0);
    chk("search_bit_hold", bit_cnt, 4);
    step(1, 0, 0);
    chk("relock_b24", locked, 1);
    chk("relock_err", err_cnt, 4);

    step(1, 1, 1);
    chk("clrflip_err", err_cnt, 0);
    chk("clrflip_bit", bit_cnt, 0);
    chk("clrflip_pulse", err_pulse, 1);
    chk("clrflip_locked", locked, 1);

    repeat (10) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    chk("toggle_bit", bit_cnt, 10);
    chk("toggle_err", err_cnt, 0);
    chk("toggle_pulse", err_pulse, 0);
    chk("toggle_locked", locked, 1);

    do_reset(8'hB8, 8'hFF);
    chk("rst2_locked", locked, 0);
    chk("rst2_bit", bit_cnt, 0);
    chk("rst2_err", err_cnt, 0);
    repeat (23) step(1, 0, 0);
    chk("b8_lock_b23", locked, 0);
    step(1, 0, 0);
    chk("b8_lock_b24", locked, 1);

    do_reset(8'h1D, 8'h01);
    repeat (200) step_raw(1, 1'b0, 1'b0);
    chk("zero_locked", locked, 0);
    chk("zero_err", err_cnt, 0);
    chk("zero_bit", bit_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
